gearbox_1_to_n: RTL

Parametrised upstream-to-wide gearbox. It packs `n` consecutive `width`-bit beats into one `n*width`-bit word, with valid/ready backpressure on both sides and packet-end flush of partial words. It sits between a narrow producer and a wide consumer, and generalises the fixed 1:2 packer to any ratio. Output is fully registered.

---
 rtl/gearbox_1_to_n_if.sv | 26 ++
 rtl/gearbox_1_to_n.sv | 68 ++++++
 2 files changed

// File: rtl/gearbox_1_to_n_if.sv
// Handshake bundle for the 1:n gearbox: narrow upstream beats in, wide packed words out.
// The gearbox uses the slave modport; the driving/consuming environment uses master.
interface gearbox_1_to_n_if #(
    parameter int unsigned width = 8,
    parameter int unsigned n     = 4
);
    logic                       up_vld;
    logic                       up_rdy;
    logic [width-1:0]           up_data;
    logic                       up_last;
    logic                       down_vld;
    logic                       down_rdy;
    logic [n*width-1:0]         down_data;
    logic [$clog2(n+1)-1:0]     down_cnt;
    logic                       down_last;

    modport slave (
        input  up_vld, up_data, up_last, down_rdy,
        output up_rdy, down_vld, down_data, down_cnt, down_last
    );

    modport master (
        output up_vld, up_data, up_last, down_rdy,
        input  up_rdy, down_vld, down_data, down_cnt, down_last
    );
endinterface

// File: rtl/gearbox_1_to_n.sv
// Packs n consecutive width-bit beats into one n*width-bit word (first beat in the MSBs),
// flushing a partial word early on up_last. Output register is fully registered.
module gearbox_1_to_n #(
    parameter int unsigned width = 8,
    parameter int unsigned n     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    gearbox_1_to_n_if.slave      bus,
    output logic                 busy
);
    localparam int unsigned kw = $clog2(n);
    localparam int unsigned cw = $clog2(n + 1);
    localparam logic [kw-1:0] k_max = kw'(n - 1);

    logic [kw-1:0]       k;
    logic [width-1:0]    lanes [n];
    logic [n*width-1:0]  word;
    logic                accept;
    logic                complete;

    assign bus.up_rdy = !bus.down_vld || bus.down_rdy;
    assign accept     = bus.up_vld && bus.up_rdy;
    assign complete   = accept && ((k == k_max) || bus.up_last);

    // Candidate output word: held lanes below k, the incoming beat at lane k, zeros above.
    always_comb begin
        logic [n*width-1:0] lane_ext;
        word = '0;
        for (int unsigned i = 0; i < n; i++) begin
            lane_ext = '0;
            if (kw'(i) < k)
                lane_ext[width-1:0] = lanes[kw'(i)];
            else if (kw'(i) == k)
                lane_ext[width-1:0] = bus.up_data;
            word = word | (lane_ext << ((n - 1 - i) * width));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k             <= '0;
            busy          <= 1'b0;
            bus.down_vld  <= 1'b0;
            bus.down_data <= '0;
            bus.down_cnt  <= '0;
            bus.down_last <= 1'b0;
        end else begin
            // Drain first so a same-cycle completing beat re-asserts down_vld below.
            if (bus.down_vld && bus.down_rdy)
                bus.down_vld <= 1'b0;
            if (accept) begin
                if (complete) begin
                    bus.down_vld  <= 1'b1;
                    bus.down_data <= word;
                    bus.down_cnt  <= cw'(k) + cw'(1);
                    bus.down_last <= bus.up_last;
                    k             <= '0;
                    busy          <= 1'b0;
                end else begin
                    lanes[k] <= bus.up_data;
                    k        <= k + kw'(1);
                    busy     <= 1'b1;
                end
            end
        end
    end
endmodule
